// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, colour type and axis phase encoding for vga_timing_gen.
// Also holds the colour-bar lookup used when VGA_TEST_PATTERN_EN is defined.
package vga_timing_gen_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int CLK_DIV   = 2;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } axis_phase_e;

    // Eight 80-pixel bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t colour_bar(input logic [9:0] x);
        logic [2:0] idx;
        logic [2:0] bits;
        rgb_t       c;
        idx = 3'(x / 10'd80);
        case (idx)
            3'd0:    bits = 3'b111;
            3'd1:    bits = 3'b110;
            3'd2:    bits = 3'b011;
            3'd3:    bits = 3'b010;
            3'd4:    bits = 3'b101;
            3'd5:    bits = 3'b100;
            3'd6:    bits = 3'b001;
            default: bits = 3'b000;
        endcase
        c.r = {8{bits[2]}};
        c.g = {8{bits[1]}};
        c.b = {8{bits[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Colour-in / raster-out bundle between the timing generator (master) and colour logic or DAC (slave).
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if;

    logic [7:0] Red_in;
    logic [7:0] Green_in;
    logic [7:0] Blue_in;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode;
`endif
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pixel_clk;
    logic       pixel_ce;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       frame_start;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        input  Red_in, Green_in, Blue_in,
`ifdef VGA_TEST_PATTERN_EN
        input  test_mode,
`endif
        output DrawX, DrawY, pixel_clk, pixel_ce, hs, vs, blank, sync, frame_start,
        output VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output Red_in, Green_in, Blue_in,
`ifdef VGA_TEST_PATTERN_EN
        output test_mode,
`endif
        input  DrawX, DrawY, pixel_clk, pixel_ce, hs, vs, blank, sync, frame_start,
        input  VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter advanced by ce, plus phase decode
// (active, front porch, sync, back porch) giving active-low sync and active flags.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 751,
    parameter int VISIBLE    = 640
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ce,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       sync_n,
    output logic       active
);

    localparam logic [9:0] LAST       = 10'(TOTAL - 1);
    localparam logic [9:0] VIS_END    = 10'(VISIBLE);
    localparam logic [9:0] SYNC_FIRST = 10'(SYNC_START);
    localparam logic [9:0] SYNC_LAST  = 10'(SYNC_END);

    logic [9:0]  r_cnt;
    axis_phase_e w_phase;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (ce) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 10'd1;
        end
    end

    always_comb begin
        if (r_cnt < VIS_END) begin
            w_phase = PH_ACTIVE;
        end else if (r_cnt < SYNC_FIRST) begin
            w_phase = PH_FP;
        end else if (r_cnt <= SYNC_LAST) begin
            w_phase = PH_SYNC;
        end else begin
            w_phase = PH_BP;
        end
    end

    assign cnt    = r_cnt;
    assign wrap   = ce && (r_cnt == LAST);
    assign sync_n = (w_phase != PH_SYNC);
    assign active = (w_phase == PH_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V counters and a one-pixel colour/sync pipeline.
// Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar source.
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_timing_gen_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_gen_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_gen_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_gen_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_gen_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_gen_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_gen_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_gen_pkg::V_BP,
    parameter int CLK_DIV   = vga_timing_gen_pkg::CLK_DIV
) (
    input  logic             Clk,
    input  logic             Reset,
    vga_timing_gen_if.master bus
);
    import vga_timing_gen_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_divNext;
    logic             r_pixelCe;
    logic             r_pixelClk;
    logic [9:0]       w_hc;
    logic [9:0]       w_vc;
    logic             w_hWrap;
    logic             w_vWrap;
    logic             w_hSyncN;
    logic             w_vSyncN;
    logic             w_hActive;
    logic             w_vActive;
    logic             w_blankRaw;
    rgb_t             w_colour;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank;
    rgb_t             r_rgb;

    assign w_divNext = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

    // pixel_ce and pixel_clk are predicted one Clk ahead so both come straight from flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div      <= '0;
            r_pixelCe  <= 1'b0;
            r_pixelClk <= 1'b0;
        end else begin
            r_div      <= w_divNext;
            r_pixelCe  <= (r_div == DIV_PRE);
            r_pixelClk <= (w_divNext < DIV_HALF);
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_VISIBLE + H_FP + H_SYNC + H_BP),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_END   (H_VISIBLE + H_FP + H_SYNC - 1),
        .VISIBLE    (H_VISIBLE)
    ) u_hAxis (
        .Clk    (Clk),
        .Reset  (Reset),
        .ce     (r_pixelCe),
        .cnt    (w_hc),
        .wrap   (w_hWrap),
        .sync_n (w_hSyncN),
        .active (w_hActive)
    );

    vga_axis_counter #(
        .TOTAL      (V_VISIBLE + V_FP + V_SYNC + V_BP),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_END   (V_VISIBLE + V_FP + V_SYNC - 1),
        .VISIBLE    (V_VISIBLE)
    ) u_vAxis (
        .Clk    (Clk),
        .Reset  (Reset),
        .ce     (w_hWrap),
        .cnt    (w_vc),
        .wrap   (w_vWrap),
        .sync_n (w_vSyncN),
        .active (w_vActive)
    );

    assign w_blankRaw = w_hActive & w_vActive;

    always_comb begin
        w_colour.r = bus.Red_in;
        w_colour.g = bus.Green_in;
        w_colour.b = bus.Blue_in;
`ifdef VGA_TEST_PATTERN_EN
        if (bus.test_mode) begin
            w_colour = colour_bar(w_hc);
        end
`endif
    end

    // Colour and sync are captured together so they reach the DAC pins in the same pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b0;
            r_rgb   <= '0;
        end else if (r_pixelCe) begin
            r_hs    <= w_hSyncN;
            r_vs    <= w_vSyncN;
            r_blank <= w_blankRaw;
            r_rgb   <= w_blankRaw ? w_colour : '0;
        end
    end

    assign bus.DrawX       = w_hc;
    assign bus.DrawY       = w_vc;
    assign bus.pixel_clk   = r_pixelClk;
    assign bus.pixel_ce    = r_pixelCe;
    assign bus.hs          = r_hs;
    assign bus.vs          = r_vs;
    assign bus.blank       = r_blank;
    assign bus.sync        = 1'b0;
    assign bus.frame_start = w_vWrap;
    assign bus.VGA_R       = r_rgb.r;
    assign bus.VGA_G       = r_rgb.g;
    assign bus.VGA_B       = r_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size 640x480 instance for line-level behaviour and a
// shrunken-raster instance (16x9 totals) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic Clk;
    logic Reset;
    logic sReset;
    int   errors;
    int   checks;

    // Expected raster position and pin values of the full-size instance.
    int         mx;
    int         my;
    logic       exHs;
    logic       exVs;
    logic       exBlank;
    logic [7:0] exR;
    logic [7:0] exG;
    logic [7:0] exB;

    vga_timing_gen_if bus ();
    vga_timing_gen_if sbus ();

    vga_timing_gen u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3),
        .V_VISIBLE (4),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (2),
        .CLK_DIV   (2)
    ) u_small (
        .Clk   (Clk),
        .Reset (sReset),
        .bus   (sbus)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    // Holds reset for 3 Clk and returns on the negedge where it is released.
    task automatic apply_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset   = 1'b0;
        mx      = 0;
        my      = 0;
        exHs    = 1'b1;
        exVs    = 1'b1;
        exBlank = 1'b0;
        exR     = 8'h00;
        exG     = 8'h00;
        exB     = 8'h00;
    endtask

    // Called on a pixel_ce sample once the colour inputs for this pixel are set.
    task automatic step_pixel();
        exHs    = !(mx >= 656 && mx <= 751);
        exVs    = !(my >= 490 && my <= 491);
        exBlank = (mx < 640) && (my < 480);
        exR     = exBlank ? bus.Red_in : 8'h00;
        exG     = exBlank ? bus.Green_in : 8'h00;
        exB     = exBlank ? bus.Blue_in : 8'h00;
        if (mx == 799) begin
            mx = 0;
            my = (my == 524) ? 0 : my + 1;
        end else begin
            mx++;
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        int bad;
        apply_reset();
        checks++;
        if (bus.DrawX !== 10'd0 || bus.DrawY !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: DrawX=%0d DrawY=%0d, required 0/0", bus.DrawX, bus.DrawY);
        end
        checks++;
        if ({bus.hs, bus.vs, bus.blank, bus.sync} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL reset_sync: hs/vs/blank/sync=%b, required 1100",
                     {bus.hs, bus.vs, bus.blank, bus.sync});
        end
        checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h000000) begin
            errors++;
            $display("[TB] FAIL reset_colour: rgb=%h, required 000000", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        checks++;
        if ({bus.pixel_ce, bus.pixel_clk, bus.frame_start} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: ce/pclk/fs=%b, required 000",
                     {bus.pixel_ce, bus.pixel_clk, bus.frame_start});
        end
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            if (bus.pixel_ce !== ((k % 2) == 1) || bus.pixel_clk !== ((k % 2) == 0) ||
                bus.DrawX !== 10'(k / 2)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL reset_cadence: bad samples=%0d, required 0", bad);
        end
    endtask

    task automatic test_red_line();
        int bad;
        int hsLow;
        int firstHsLow;
        int redCount;
        apply_reset();
        bus.Red_in   = 8'h00;
        bus.Green_in = 8'h00;
        bus.Blue_in  = 8'h00;
        @(negedge Clk);
        bad        = 0;
        hsLow      = 0;
        firstHsLow = -1;
        redCount   = 0;
        for (int i = 0; i < 801; i++) begin
            if (bus.DrawX !== 10'(mx) || bus.DrawY !== 10'(my) || bus.hs !== exHs || bus.vs !== exVs ||
                bus.blank !== exBlank || bus.VGA_R !== exR || bus.pixel_ce !== 1'b1) bad++;
            if (bus.hs === 1'b0) begin
                hsLow++;
                if (firstHsLow < 0) firstHsLow = mx;
            end
            if (bus.VGA_R === 8'hAA) redCount++;
            bus.Red_in = 8'hAA;
            step_pixel();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL red_line_pixels: bad samples=%0d, required 0", bad);
        end
        checks++;
        if (hsLow !== 96) begin
            errors++;
            $display("[TB] FAIL hs_width: low pixels=%0d, required 96", hsLow);
        end
        checks++;
        if (firstHsLow !== 657) begin
            errors++;
            $display("[TB] FAIL hs_start: first low at DrawX=%0d, required 657", firstHsLow);
        end
        checks++;
        if (redCount !== 640) begin
            errors++;
            $display("[TB] FAIL red_count: AA pixels=%0d, required 640", redCount);
        end
    endtask

    task automatic test_green_pipeline();
        int         bad;
        logic [7:0] g101;
        logic [7:0] g200;
        logic [7:0] g641;
        apply_reset();
        bus.Red_in  = 8'h00;
        bus.Blue_in = 8'h00;
        @(negedge Clk);
        bad  = 0;
        g101 = 8'hxx;
        g200 = 8'hxx;
        g641 = 8'hxx;
        for (int i = 0; i < 801; i++) begin
            if (bus.VGA_G !== exG || bus.blank !== exBlank || bus.DrawX !== 10'(mx)) bad++;
            if (mx == 101) g101 = bus.VGA_G;
            if (mx == 200) g200 = bus.VGA_G;
            if (mx == 641) g641 = bus.VGA_G;
            bus.Green_in = 8'(mx);
            step_pixel();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL green_pipeline: bad samples=%0d, required 0", bad);
        end
        checks++;
        if (g101 !== 8'd100) begin
            errors++;
            $display("[TB] FAIL green_x101: VGA_G=%h, required 64", g101);
        end
        checks++;
        if (g200 !== 8'hC7) begin
            errors++;
            $display("[TB] FAIL green_x200: VGA_G=%h, required c7", g200);
        end
        checks++;
        if (g641 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL green_blanked: VGA_G=%h, required 00", g641);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        apply_reset();
        bus.Green_in = 8'h00;
        bus.Blue_in  = 8'h00;
        @(negedge Clk);
        bad = 0;
        for (int i = 0; i < 2000 && !(mx == 300 && my == 1); i++) begin
            if (bus.DrawX !== 10'(mx) || bus.DrawY !== 10'(my)) bad++;
            bus.Red_in = 8'h55;
            step_pixel();
        end
        checks++;
        if (bad !== 0 || bus.DrawX !== 10'd300 || bus.DrawY !== 10'd1) begin
            errors++;
            $display("[TB] FAIL mid_reached: DrawX=%0d DrawY=%0d bad=%0d, required 300/1/0",
                     bus.DrawX, bus.DrawY, bad);
        end
        checks++;
        if (bus.blank !== 1'b1 || bus.VGA_R !== 8'h55) begin
            errors++;
            $display("[TB] FAIL mid_pins: blank=%b VGA_R=%h, required 1/55", bus.blank, bus.VGA_R);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (bus.DrawX !== 10'd0 || bus.DrawY !== 10'd0 || {bus.hs, bus.vs, bus.blank} !== 3'b110 ||
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h000000 ||
            {bus.pixel_ce, bus.pixel_clk, bus.frame_start} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: x=%0d y=%0d hs/vs/blank=%b rgb=%h ce/pclk/fs=%b, required 0 0 110 000000 000",
                     bus.DrawX, bus.DrawY, {bus.hs, bus.vs, bus.blank}, {bus.VGA_R, bus.VGA_G, bus.VGA_B},
                     {bus.pixel_ce, bus.pixel_clk, bus.frame_start});
        end
        bad = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            if (bus.pixel_ce !== ((k % 2) == 1) || bus.DrawX !== 10'(k / 2) || bus.DrawY !== 10'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL mid_restart: bad samples=%0d, required 0", bad);
        end
    endtask

    task automatic test_frames();
        int sx;
        int sy;
        int bad;
        int fsCount;
        int fsMisplaced;
        int vsLow;
        int hsLow;
        int blankHigh;
        int maxY;
        sReset = 1'b1;
        repeat (3) @(negedge Clk);
        sReset = 1'b0;
        @(negedge Clk);
        sx          = 0;
        sy          = 0;
        bad         = 0;
        fsCount     = 0;
        fsMisplaced = 0;
        vsLow       = 0;
        hsLow       = 0;
        blankHigh   = 0;
        maxY        = 0;
        for (int k = 0; k < 576; k++) begin
            if (sbus.frame_start === 1'b1) begin
                fsCount++;
                if (!((k % 2) == 0 && sx == 15 && sy == 8)) fsMisplaced++;
            end
            if ((k % 2) == 0) begin
                if (sbus.DrawX !== 10'(sx) || sbus.DrawY !== 10'(sy) || sbus.pixel_ce !== 1'b1) bad++;
                if (sbus.vs === 1'b0) vsLow++;
                if (sbus.hs === 1'b0) hsLow++;
                if (sbus.blank === 1'b1) blankHigh++;
                if (int'(sbus.DrawY) > maxY) maxY = int'(sbus.DrawY);
                if (sx == 15) begin
                    sx = 0;
                    sy = (sy == 8) ? 0 : sy + 1;
                end else begin
                    sx++;
                end
            end
            @(negedge Clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL frame_raster: bad samples=%0d, required 0", bad);
        end
        checks++;
        if (fsCount !== 2) begin
            errors++;
            $display("[TB] FAIL frame_start_count: pulses=%0d, required 2", fsCount);
        end
        checks++;
        if (fsMisplaced !== 0) begin
            errors++;
            $display("[TB] FAIL frame_start_place: misplaced=%0d, required 0", fsMisplaced);
        end
        checks++;
        if (vsLow !== 64) begin
            errors++;
            $display("[TB] FAIL vs_width: low pixels=%0d, required 64", vsLow);
        end
        checks++;
        if (hsLow !== 54) begin
            errors++;
            $display("[TB] FAIL small_hs: low pixels=%0d, required 54", hsLow);
        end
        checks++;
        if (blankHigh !== 64) begin
            errors++;
            $display("[TB] FAIL small_visible: visible pixels=%0d, required 64", blankHigh);
        end
        checks++;
        if (maxY !== 8) begin
            errors++;
            $display("[TB] FAIL drawy_max: max=%0d, required 8", maxY);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [23:0] c101;
        logic [23:0] c501;
        apply_reset();
        bus.test_mode = 1'b1;
        bus.Red_in    = 8'h12;
        bus.Green_in  = 8'h34;
        bus.Blue_in   = 8'h56;
        @(negedge Clk);
        c101 = 24'hxxxxxx;
        c501 = 24'hxxxxxx;
        for (int i = 0; i < 502; i++) begin
            if (mx == 101) c101 = {bus.VGA_R, bus.VGA_G, bus.VGA_B};
            if (mx == 501) c501 = {bus.VGA_R, bus.VGA_G, bus.VGA_B};
            step_pixel();
        end
        checks++;
        if (c101 !== 24'hFFFF00) begin
            errors++;
            $display("[TB] FAIL bar_x100: rgb=%h, required ffff00", c101);
        end
        checks++;
        if (c501 !== 24'h0000FF) begin
            errors++;
            $display("[TB] FAIL bar_x500: rgb=%h, required 0000ff", c501);
        end
        bus.test_mode = 1'b0;
    endtask
`endif

    initial begin
        errors        = 0;
        checks        = 0;
        Reset         = 1'b1;
        sReset        = 1'b1;
        bus.Red_in    = 8'h00;
        bus.Green_in  = 8'h00;
        bus.Blue_in   = 8'h00;
        sbus.Red_in   = 8'h00;
        sbus.Green_in = 8'h00;
        sbus.Blue_in  = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
        bus.test_mode  = 1'b0;
        sbus.test_mode = 1'b0;
`endif
        $display("[TB] starting vga_timing_gen bench");
        test_reset();
        test_red_line();
        test_green_pipeline();
        test_mid_reset();
        test_frames();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
